// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared encodings for the traffic-light timer datapath
package tlc_pkg;

  localparam logic [1:0] LIGHT_RED     = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW  = 2'b01;
  localparam logic [1:0] LIGHT_GREEN   = 2'b10;
  localparam logic [1:0] LIGHT_INVALID = 2'b11;

  localparam logic TSEL_GREEN  = 1'b0;
  localparam logic TSEL_YELLOW = 1'b1;

  localparam int LAMP_R = 2;
  localparam int LAMP_Y = 1;
  localparam int LAMP_G = 0;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_CONFLICT = 2'b01;
  localparam logic [1:0] FAULT_INVALID  = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    EXPIRE    = 2'b01,
    WAIT_LOAD = 2'b10
  } timer_state_t;

  // Invalid commands decode to red so a bad command can never light green.
  function automatic logic [2:0] lamp_decode(input logic [1:0] cmd);
    logic [2:0] lamp;
    lamp = '0;
    case (cmd)
      LIGHT_YELLOW: lamp[LAMP_Y] = 1'b1;
      LIGHT_GREEN:  lamp[LAMP_G] = 1'b1;
      default:      lamp[LAMP_R] = 1'b1;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/tlc_tick_prescaler.sv
// rtl/tlc_tick_prescaler.sv - divides clk into one-cycle ticks every TICK_DIV cycles
module tlc_tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] cnt;

  assign tick = (cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/tlc_timer_datapath.sv
// rtl/tlc_timer_datapath.sv - phase timer, expiry handshake, watchdog and lamp safety checker
module tlc_timer_datapath
  import tlc_pkg::*;
#(
  parameter int GREEN_TIME   = 10,
  parameter int YELLOW_TIME  = 3,
  parameter int TICK_DIV     = 4,
  parameter int CNT_W        = 8,
  parameter int LOAD_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_enable,
  input  logic             time_sel,
  input  logic [1:0]       ns_light_cmd,
  input  logic [1:0]       ew_light_cmd,
  output logic             timer_zero,
  output logic [CNT_W-1:0] remaining_ticks,
  output logic [2:0]       ns_lamp,
  output logic [2:0]       ew_lamp,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int WD_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(LOAD_TIMEOUT - 1);

  timer_state_t    state, state_n;
  logic [CNT_W-1:0] count, count_n;
  logic [WD_W-1:0]  wd_cnt, wd_n;
  logic             tz_n;
  logic             tick;
  logic             timeout_det;
  logic             conflict_det;
  logic             invalid_det;
  logic [1:0]       cause;

  tlc_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (load_enable),
    .tick  (tick)
  );

  assign remaining_ticks = count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      count      <= CNT_W'(GREEN_TIME);
      wd_cnt     <= '0;
      timer_zero <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      wd_cnt     <= wd_n;
      timer_zero <= tz_n;
    end
  end

  // A load in any state restarts the phase and pre-empts a coincident expiry.
  always_comb begin
    state_n     = state;
    count_n     = count;
    wd_n        = '0;
    tz_n        = 1'b0;
    timeout_det = 1'b0;
    if (load_enable) begin
      state_n = RUN;
      count_n = (time_sel == TSEL_YELLOW) ? CNT_W'(YELLOW_TIME) : CNT_W'(GREEN_TIME);
    end else begin
      case (state)
        RUN: begin
          if (tick) begin
            if (count == CNT_W'(1)) begin
              count_n = '0;
              tz_n    = 1'b1;
              state_n = EXPIRE;
            end else if (count != '0) begin
              count_n = count - CNT_W'(1);
            end
          end
        end
        EXPIRE: begin
          state_n = WAIT_LOAD;
        end
        WAIT_LOAD: begin
          count_n     = '0;
          timeout_det = (wd_cnt == WD_LAST);
          wd_n        = (wd_cnt == WD_LAST) ? wd_cnt : wd_cnt + WD_W'(1);
        end
        default: begin
          state_n = RUN;
        end
      endcase
    end
  end

  assign conflict_det = (ns_light_cmd != LIGHT_RED) && (ew_light_cmd != LIGHT_RED);
  assign invalid_det  = (ns_light_cmd == LIGHT_INVALID) || (ew_light_cmd == LIGHT_INVALID);

  always_comb begin
    cause = FAULT_NONE;
    if (conflict_det)      cause = FAULT_CONFLICT;
    else if (invalid_det)  cause = FAULT_INVALID;
    else if (timeout_det)  cause = FAULT_TIMEOUT;
  end

  // fault_code keeps the first cause; lamps fall back to all-red once faulted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_code <= FAULT_NONE;
      ns_lamp    <= 3'b100;
      ew_lamp    <= 3'b100;
    end else begin
      if (!fault && (cause != FAULT_NONE)) begin
        fault      <= 1'b1;
        fault_code <= cause;
      end
      if (fault || conflict_det || invalid_det) begin
        ns_lamp <= 3'b100;
        ew_lamp <= 3'b100;
      end else begin
        ns_lamp <= lamp_decode(ns_light_cmd);
        ew_lamp <= lamp_decode(ew_light_cmd);
      end
    end
  end

endmodule

// File: tb/tb_tlc_timer_datapath.sv
// tb/tb_tlc_timer_datapath.sv - directed vector bench for tlc_timer_datapath
module tb_tlc_timer_datapath;

  logic       clk;
  logic       reset;
  logic       load_enable;
  logic       time_sel;
  logic [1:0] ns_cmd;
  logic [1:0] ew_cmd;
  logic       timer_zero;
  logic [7:0] remaining_ticks;
  logic [2:0] ns_lamp;
  logic [2:0] ew_lamp;
  logic       fault;
  logic [1:0] fault_code;

  int tests;
  int fails;
  int n;
  int tz_cnt;

  typedef struct {
    logic [1:0] ns;
    logic [1:0] ew;
    logic [2:0] exp_ns;
    logic [2:0] exp_ew;
  } vec_t;

  vec_t vecs[5];

  tlc_timer_datapath dut (
    .clk             (clk),
    .reset           (reset),
    .load_enable     (load_enable),
    .time_sel        (time_sel),
    .ns_light_cmd    (ns_cmd),
    .ew_light_cmd    (ew_cmd),
    .timer_zero      (timer_zero),
    .remaining_ticks (remaining_ticks),
    .ns_lamp         (ns_lamp),
    .ew_lamp         (ew_lamp),
    .fault           (fault),
    .fault_code      (fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
    if (timer_zero) tz_cnt++;
  endtask

  task automatic step_to(input int target);
    while (n < target) step();
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    n      = 0;
    tz_cnt = 0;
  endtask

  initial begin
    tests = 0; fails = 0; n = 0; tz_cnt = 0;
    clk = 1'b0; reset = 1'b1; load_enable = 1'b0; time_sel = 1'b0;
    ns_cmd = 2'b00; ew_cmd = 2'b00;

    vecs[0] = '{2'b00, 2'b00, 3'b100, 3'b100};
    vecs[1] = '{2'b01, 2'b00, 3'b010, 3'b100};
    vecs[2] = '{2'b10, 2'b00, 3'b001, 3'b100};
    vecs[3] = '{2'b00, 2'b01, 3'b100, 3'b010};
    vecs[4] = '{2'b00, 2'b10, 3'b100, 3'b001};

    // Reset values, lamp decode, default green expiry and watchdog
    repeat (2) @(negedge clk);
    chk("rst_count", int'(remaining_ticks), 10);
    chk("rst_tz", int'(timer_zero), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_code", int'(fault_code), 0);
    chk("rst_ns_lamp", int'(ns_lamp), 4);
    chk("rst_ew_lamp", int'(ew_lamp), 4);
    reset = 1'b0; n = 0; tz_cnt = 0;

    for (int i = 0; i < 5; i++) begin
      ns_cmd = vecs[i].ns;
      ew_cmd = vecs[i].ew;
      step();
      chk($sformatf("vec%0d_ns", i), int'(ns_lamp), int'(vecs[i].exp_ns));
      chk($sformatf("vec%0d_ew", i), int'(ew_lamp), int'(vecs[i].exp_ew));
      chk($sformatf("vec%0d_fault", i), int'(fault), 0);
    end

    ns_cmd = 2'b10; ew_cmd = 2'b00;
    step_to(39);
    chk("green_cnt_39", int'(remaining_ticks), 1);
    chk("green_no_early_tz", tz_cnt, 0);
    step();
    chk("green_tz_40", int'(timer_zero), 1);
    chk("green_cnt_40", int'(remaining_ticks), 0);
    chk("green_ns_lamp", int'(ns_lamp), 1);
    chk("green_ew_lamp", int'(ew_lamp), 4);
    step();
    chk("expire_one_cycle", int'(timer_zero), 0);
    step_to(44);
    chk("wd_no_fault_44", int'(fault), 0);
    step();
    chk("wd_fault_45", int'(fault), 1);
    chk("wd_code_45", int'(fault_code), 3);
    chk("wd_single_pulse", tz_cnt, 1);
    chk("wd_cnt_holds", int'(remaining_ticks), 0);

    // Yellow load, WAIT_LOAD reload, load coinciding with expiry
    ns_cmd = 2'b10; ew_cmd = 2'b00;
    reset_pulse();
    step_to(2);
    load_enable = 1'b1; time_sel = 1'b1;
    step();
    load_enable = 1'b0;
    chk("yel_cnt", int'(remaining_ticks), 3);
    step_to(14);
    chk("yel_no_early_tz", tz_cnt, 0);
    step();
    chk("yel_tz_15", int'(timer_zero), 1);
    step();
    chk("yel_tz_16", int'(timer_zero), 0);
    chk("yel_wait_cnt", int'(remaining_ticks), 0);
    load_enable = 1'b1; time_sel = 1'b0;
    step();
    load_enable = 1'b0;
    chk("reload_cnt", int'(remaining_ticks), 10);
    step_to(56);
    load_enable = 1'b1; time_sel = 1'b0;
    step();
    load_enable = 1'b0;
    chk("coinc_no_tz", int'(timer_zero), 0);
    chk("coinc_cnt", int'(remaining_ticks), 10);
    step_to(96);
    chk("coinc_pulse_count", tz_cnt, 1);
    step();
    chk("coinc_next_tz_97", int'(timer_zero), 1);
    chk("coinc_no_fault", int'(fault), 0);

    // Conflict, sticky first code, async reset mid-run
    ns_cmd = 2'b10; ew_cmd = 2'b01;
    reset_pulse();
    step();
    chk("conf_ns_lamp", int'(ns_lamp), 4);
    chk("conf_ew_lamp", int'(ew_lamp), 4);
    chk("conf_fault", int'(fault), 1);
    chk("conf_code", int'(fault_code), 1);
    ns_cmd = 2'b11; ew_cmd = 2'b00;
    step();
    chk("conf_code_sticky", int'(fault_code), 1);
    ns_cmd = 2'b10;
    step();
    chk("conf_lamp_held", int'(ns_lamp), 4);
    step_to(20);
    chk("conf_timer_runs", int'(remaining_ticks), 5);
    #2 reset = 1'b1;
    #1;
    chk("async_cnt", int'(remaining_ticks), 10);
    chk("async_ns_lamp", int'(ns_lamp), 4);
    chk("async_ew_lamp", int'(ew_lamp), 4);
    chk("async_fault", int'(fault), 0);
    chk("async_code", int'(fault_code), 0);
    @(negedge clk);
    reset = 1'b0; n = 0; tz_cnt = 0;
    step();
    chk("post_rst_ns_lamp", int'(ns_lamp), 1);
    step_to(39);
    chk("post_rst_no_early_tz", tz_cnt, 0);
    step();
    chk("post_rst_tz_40", int'(timer_zero), 1);

    // Invalid command, and conflict priority over invalid
    ns_cmd = 2'b11; ew_cmd = 2'b00;
    reset_pulse();
    step();
    chk("inv_code", int'(fault_code), 2);
    chk("inv_ns_lamp", int'(ns_lamp), 4);
    ns_cmd = 2'b11; ew_cmd = 2'b01;
    reset_pulse();
    step();
    chk("prio_code", int'(fault_code), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
